// File: rtl/router_pkg.sv
// Shared widths, the reserved destination code and the router FSM state
// encoding used by router_reg, the FSM and the sync block.
package router_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 2;

   // Destination 3 does not exist in a 1x3 router, so such headers are dropped.
   localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      WAIT_TILL_EMPTY    = 3'd3,
      FIFO_FULL_STATE    = 3'd4,
      LOAD_AFTER_FULL    = 3'd5,
      LOAD_PARITY        = 3'd6,
      CHECK_PARITY_ERROR = 3'd7
   } router_state_e;

endpackage : router_pkg

// File: rtl/router_parity.sv
// Running XOR parity over header and payload, packet parity capture and the
// one-shot compare that produces err.
module router_parity #(
   parameter int DATA_W = router_pkg::DATA_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              pkt_valid_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              fifo_full_i,
   input  logic [DATA_W-1:0] hdr_i,
   input  logic [DATA_W-1:0] hold_byte_i,
   input  logic              hold_last_i,
   input  logic              detect_add_i,
   input  logic              lfd_i,
   input  logic              ld_i,
   input  logic              laf_i,
   output logic              parity_done_o,
   output logic              err_o
);
   import router_pkg::*;

   logic [DATA_W-1:0] int_parity_q, int_parity_d;
   logic [DATA_W-1:0] pkt_parity_q, pkt_parity_d;
   logic              parity_done_q, parity_done_d;
   logic              chk_pend_q, chk_pend_d;
   logic              err_q, err_d;
   logic              cap_ld, cap_laf;

   // The parity byte reaches us either straight from the input or from the hold register.
   assign cap_ld  = ld_i && !pkt_valid_i && !fifo_full_i;
   assign cap_laf = laf_i && hold_last_i;

   always_comb begin
      int_parity_d  = int_parity_q;
      pkt_parity_d  = pkt_parity_q;
      parity_done_d = parity_done_q;
      err_d         = err_q;
      chk_pend_d    = cap_ld || cap_laf;

      if (detect_add_i)                                 int_parity_d = '0;
      else if (lfd_i)                                   int_parity_d = int_parity_q ^ hdr_i;
      else if (ld_i && pkt_valid_i && !fifo_full_i)     int_parity_d = int_parity_q ^ data_i;
      else if (laf_i && !hold_last_i)                   int_parity_d = int_parity_q ^ hold_byte_i;

      if (cap_ld)            pkt_parity_d = data_i;
      else if (cap_laf)      pkt_parity_d = hold_byte_i;
      else if (detect_add_i) pkt_parity_d = '0;

      if (cap_ld || cap_laf) parity_done_d = 1'b1;
      else if (detect_add_i) parity_done_d = 1'b0;

      // Compare one cycle after capture so both parities are settled registers.
      if (chk_pend_q)                       err_d = (int_parity_q != pkt_parity_q);
      else if (detect_add_i && pkt_valid_i) err_d = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         int_parity_q  <= '0;
         pkt_parity_q  <= '0;
         parity_done_q <= 1'b0;
         chk_pend_q    <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         int_parity_q  <= int_parity_d;
         pkt_parity_q  <= pkt_parity_d;
         parity_done_q <= parity_done_d;
         chk_pend_q    <= chk_pend_d;
         err_q         <= err_d;
      end
   end

   assign parity_done_o = parity_done_q;
   assign err_o         = err_q;

endmodule : router_parity

// File: rtl/router_reg.sv
// Router datapath register stage: header latch, full-FIFO hold byte and the
// registered FIFO write byte; parity tracking lives in router_parity.
module router_reg #(
   parameter int DATA_W = router_pkg::DATA_W,
   parameter int ADDR_W = router_pkg::ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pkt_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic              fifo_full,
   input  logic              detect_add,
   input  logic              lfd_state,
   input  logic              ld_state,
   input  logic              laf_state,
   input  logic              full_state,
   input  logic              rst_int_reg,
   output logic [DATA_W-1:0] dout,
   output logic              parity_done,
   output logic              low_packet_valid,
   output logic              err
);
   import router_pkg::*;

   logic [DATA_W-1:0] hdr_q, hdr_d;
   logic [DATA_W-1:0] hold_byte_q, hold_byte_d;
   logic              hold_last_q, hold_last_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              lpv_q, lpv_d;
   logic              da_en, lfd_en, ld_en, laf_en;

   // FIFO_FULL_STATE freezes everything, even if another decode glitches high.
   assign da_en  = detect_add && !full_state;
   assign lfd_en = lfd_state  && !full_state;
   assign ld_en  = ld_state   && !full_state;
   assign laf_en = laf_state  && !full_state;

   always_comb begin
      hdr_d       = hdr_q;
      hold_byte_d = hold_byte_q;
      hold_last_d = hold_last_q;
      dout_d      = dout_q;
      lpv_d       = lpv_q;

      if (da_en && pkt_valid && (data_in[ADDR_W-1:0] != ADDR_INVALID))
         hdr_d = data_in;

      if (ld_en && fifo_full) begin
         hold_byte_d = data_in;
         hold_last_d = !pkt_valid;
      end

      if (lfd_en)                  dout_d = hdr_q;
      else if (ld_en && !fifo_full) dout_d = data_in;
      else if (laf_en)             dout_d = hold_byte_q;

      if (ld_en && !pkt_valid) lpv_d = 1'b1;
      else if (rst_int_reg)    lpv_d = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hdr_q       <= '0;
         hold_byte_q <= '0;
         hold_last_q <= 1'b0;
         dout_q      <= '0;
         lpv_q       <= 1'b0;
      end else begin
         hdr_q       <= hdr_d;
         hold_byte_q <= hold_byte_d;
         hold_last_q <= hold_last_d;
         dout_q      <= dout_d;
         lpv_q       <= lpv_d;
      end
   end

   router_parity #(.DATA_W(DATA_W)) u_parity (
      .clk_i         (clock),
      .rst_i         (reset),
      .pkt_valid_i   (pkt_valid),
      .data_i        (data_in),
      .fifo_full_i   (fifo_full),
      .hdr_i         (hdr_q),
      .hold_byte_i   (hold_byte_q),
      .hold_last_i   (hold_last_q),
      .detect_add_i  (da_en),
      .lfd_i         (lfd_en),
      .ld_i          (ld_en),
      .laf_i         (laf_en),
      .parity_done_o (parity_done),
      .err_o         (err)
   );

   assign dout             = dout_q;
   assign low_packet_valid = lpv_q;

endmodule : router_reg

// File: tb/tb_router_reg.sv
// Self-checking bench for router_reg: the bench plays the router FSM and
// predicts outputs from whole-packet contents.
module tb_router_reg;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       pkt_valid = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       fifo_full = 1'b0;
   logic       detect_add = 1'b0;
   logic       lfd_state = 1'b0;
   logic       ld_state = 1'b0;
   logic       laf_state = 1'b0;
   logic       full_state = 1'b0;
   logic       rst_int_reg = 1'b0;
   logic [7:0] dout;
   logic       parity_done;
   logic       low_packet_valid;
   logic       err;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] pay_q[$];
   logic [7:0] last_dout;
   logic [7:0] last_hdr;
   logic       lpv_exp;

   router_reg dut (
      .clock            (clock),
      .reset            (reset),
      .pkt_valid        (pkt_valid),
      .data_in          (data_in),
      .fifo_full        (fifo_full),
      .detect_add       (detect_add),
      .lfd_state        (lfd_state),
      .ld_state         (ld_state),
      .laf_state        (laf_state),
      .full_state       (full_state),
      .rst_int_reg      (rst_int_reg),
      .dout             (dout),
      .parity_done      (parity_done),
      .low_packet_valid (low_packet_valid),
      .err              (err)
   );

   always #5 clock = ~clock;

   // One FSM cycle: apply decodes/data, take the edge, sample 1 ns later.
   task automatic drive(input logic da, input logic lfd, input logic ld, input logic laf,
                        input logic fs, input logic ri, input logic pv,
                        input logic [7:0] d, input logic ff);
      detect_add  = da;
      lfd_state   = lfd;
      ld_state    = ld;
      laf_state   = laf;
      full_state  = fs;
      rst_int_reg = ri;
      pkt_valid   = pv;
      data_in     = d;
      fifo_full   = ff;
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   // Sends hdr, pay_q and par; full_idx selects the byte (pay_q.size() = parity)
   // that meets a full FIFO, -1 for none.
   task automatic run_packet(input logic [7:0] hdr, input logic [7:0] par,
                             input int full_idx, input string tag);
      int         n;
      logic [7:0] xr;
      logic [7:0] b;
      logic       pv;
      logic       exp_err;
      n = pay_q.size();
      xr = hdr;
      foreach (pay_q[k]) xr ^= pay_q[k];
      exp_err = (xr != par);

      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, hdr, 1'b0);
      n_checks += 3;
      if (parity_done !== 1'b0) begin n_fail++; $display("FAIL %s decode parity_done: got %b expected 0", tag, parity_done); end
      if (err !== 1'b0) begin n_fail++; $display("FAIL %s decode err: got %b expected 0", tag, err); end
      if (dout !== last_dout) begin n_fail++; $display("FAIL %s decode dout: got %h expected %h", tag, dout, last_dout); end
      last_hdr = hdr;

      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (n > 0) ? pay_q[0] : par, 1'b0);
      n_checks++;
      if (dout !== hdr) begin n_fail++; $display("FAIL %s lfd dout: got %h expected %h", tag, dout, hdr); end
      last_dout = hdr;

      for (int i = 0; i <= n; i++) begin
         b  = (i < n) ? pay_q[i] : par;
         pv = (i < n);
         if (!pv) lpv_exp = 1'b1;
         if (i == full_idx) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pv, b, 1'b1);
            n_checks += 3;
            if (dout !== last_dout) begin n_fail++; $display("FAIL %s full dout[%0d]: got %h expected %h", tag, i, dout, last_dout); end
            if (parity_done !== 1'b0) begin n_fail++; $display("FAIL %s full parity_done[%0d]: got %b expected 0", tag, i, parity_done); end
            if (low_packet_valid !== lpv_exp) begin n_fail++; $display("FAIL %s full lpv[%0d]: got %b expected %b", tag, i, low_packet_valid, lpv_exp); end
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, pv, b, 1'b1);
            n_checks += 2;
            if (dout !== last_dout) begin n_fail++; $display("FAIL %s wait dout[%0d]: got %h expected %h", tag, i, dout, last_dout); end
            if (parity_done !== 1'b0) begin n_fail++; $display("FAIL %s wait parity_done[%0d]: got %b expected 0", tag, i, parity_done); end
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, pv, b, 1'b0);
         end else begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pv, b, 1'b0);
         end
         last_dout = b;
         n_checks += 3;
         if (dout !== b) begin n_fail++; $display("FAIL %s dout[%0d]: got %h expected %h", tag, i, dout, b); end
         if (parity_done !== !pv) begin n_fail++; $display("FAIL %s parity_done[%0d]: got %b expected %b", tag, i, parity_done, !pv); end
         if (low_packet_valid !== lpv_exp) begin n_fail++; $display("FAIL %s lpv[%0d]: got %b expected %b", tag, i, low_packet_valid, lpv_exp); end
      end

      // Capture cycle has just happened; the verdict lands one cycle later.
      n_checks++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL %s err early: got %b expected 0", tag, err); end
      if (full_idx == n) begin
         idle();
      end else begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
         lpv_exp = 1'b0;
      end
      n_checks += 2;
      if (err !== exp_err) begin n_fail++; $display("FAIL %s err: got %b expected %b", tag, err, exp_err); end
      if (low_packet_valid !== lpv_exp) begin n_fail++; $display("FAIL %s lpv end: got %b expected %b", tag, low_packet_valid, lpv_exp); end
      idle();
      n_checks++;
      if (err !== exp_err) begin n_fail++; $display("FAIL %s err hold: got %b expected %b", tag, err, exp_err); end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      idle();
      reset = 1'b0;
      last_dout = 8'h00;
      lpv_exp = 1'b0;
      n_checks += 4;
      if (dout !== 8'h00) begin n_fail++; $display("FAIL reset dout: got %h expected 00", dout); end
      if (err !== 1'b0) begin n_fail++; $display("FAIL reset err: got %b expected 0", err); end
      if (parity_done !== 1'b0) begin n_fail++; $display("FAIL reset parity_done: got %b expected 0", parity_done); end
      if (low_packet_valid !== 1'b0) begin n_fail++; $display("FAIL reset lpv: got %b expected 0", low_packet_valid); end
   endtask

   task automatic test_good_packet();
      pay_q = '{8'h11, 8'h22};
      run_packet(8'h05, 8'h36, -1, "good");
   endtask

   task automatic test_bad_parity();
      pay_q = '{8'h11, 8'h22};
      run_packet(8'h05, 8'h37, -1, "bad");
      pay_q = '{8'h40};
      run_packet(8'h02, 8'h42, -1, "after_bad");
   endtask

   task automatic test_full_payload();
      pay_q = '{8'h11, 8'hAA, 8'h22};
      run_packet(8'h05, 8'h05 ^ 8'h11 ^ 8'hAA ^ 8'h22, 1, "full_pay");
   endtask

   task automatic test_full_parity();
      pay_q = '{8'h11, 8'h22};
      run_packet(8'h05, 8'h5C, 2, "full_par");
      pay_q = '{8'h0F};
      run_packet(8'h09, 8'h06, 1, "full_par_ok");
   endtask

   task automatic test_invalid_addr();
      logic [7:0] bad_hdr [2];
      bad_hdr = '{8'h03, 8'hFF};
      foreach (bad_hdr[k]) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, bad_hdr[k], 1'b0);
         drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
         n_checks++;
         if (dout !== last_hdr) begin n_fail++; $display("FAIL invalid hdr %h: got %h expected %h", bad_hdr[k], dout, last_hdr); end
         last_dout = last_hdr;
         idle();
      end
   endtask

   task automatic test_reset_mid();
      pay_q = '{8'h11, 8'h22};
      run_packet(8'h05, 8'h37, -1, "pre_reset");
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h99, 1'b0);
      reset = 1'b0;
      last_dout = 8'h00;
      lpv_exp = 1'b0;
      n_checks += 4;
      if (dout !== 8'h00) begin n_fail++; $display("FAIL midreset dout: got %h expected 00", dout); end
      if (err !== 1'b0) begin n_fail++; $display("FAIL midreset err: got %b expected 0", err); end
      if (parity_done !== 1'b0) begin n_fail++; $display("FAIL midreset parity_done: got %b expected 0", parity_done); end
      if (low_packet_valid !== 1'b0) begin n_fail++; $display("FAIL midreset lpv: got %b expected 0", low_packet_valid); end
      pay_q = '{8'h01, 8'h02, 8'h03};
      run_packet(8'h06, 8'h06, -1, "post_reset");
   endtask

   task automatic test_random();
      logic [7:0] hdr;
      logic [7:0] par;
      int         n;
      int         fidx;
      for (int p = 0; p < 16; p++) begin
         pay_q.delete();
         n = $urandom_range(1, 5);
         hdr = 8'($urandom_range(0, 255));
         if (hdr[1:0] == 2'b11) hdr[1:0] = 2'($urandom_range(0, 2));
         par = hdr;
         for (int k = 0; k < n; k++) begin
            pay_q.push_back(8'($urandom_range(0, 255)));
            par ^= pay_q[k];
         end
         if ($urandom_range(0, 2) == 0) par = 8'($urandom_range(0, 255));
         fidx = $urandom_range(0, n + 1);
         if (fidx == n + 1) fidx = -1;
         run_packet(hdr, par, fidx, $sformatf("rand%0d", p));
      end
   endtask

   initial begin
      last_dout = 8'h00;
      last_hdr  = 8'h00;
      lpv_exp   = 1'b0;
      test_reset();
      test_good_packet();
      test_bad_parity();
      test_full_payload();
      test_full_parity();
      test_invalid_addr();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_router_reg
